apb_master: RTL

APB initiator bridging a simple valid/ready command port onto an APB3 bus; it is the requester counterpart of `apb_slave`. It accepts one read or write command at a time, runs the SETUP and ACCESS phases, and honours slave wait states via PREADY. It returns read data and the PSLVERR status on a one-cycle response strobe. It sits between internal logic (CPU shim, test sequencer) and any `apb_slave` instance.

---
 rtl/apb_master.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/apb_master.sv
// -----------------------------------------------------------------------------
// apb_master
//
// APB3 initiator. Accepts one read or write command at a time on a
// valid/ready command port, runs the APB SETUP and ACCESS phases, honours
// slave wait states via PREADY and returns read data plus error status on a
// one-cycle response strobe. All outputs are registered.
//
// Optional feature macro: APB_MASTER_TIMEOUT_EN
//   defined   : ACCESS phase is aborted after TIMEOUT_CYCLES wait cycles,
//               reported as o_rsp_err=1, o_rsp_timeout=1, o_rsp_rdata=0.
//   undefined : ACCESS waits for PREADY indefinitely; o_rsp_timeout is 0.
//
// Handshake: a command transfers on a rising edge where i_cmd_valid and
// o_cmd_ready are both 1. The response has no backpressure: o_rsp_* are
// valid only in the single cycle where o_rsp_valid is 1.
//
// Ports
//   i_clk, i_reset            clock, synchronous active-high reset
//   i_cmd_valid/o_cmd_ready   command handshake
//   i_cmd_write/addr/wdata    command payload (1 = write)
//   o_rsp_valid               one-cycle completion strobe
//   o_rsp_rdata/err/timeout   completion payload
//   PADDR..PENABLE            APB requester outputs
//   PRDATA/PREADY/PSLVERR     APB completer inputs
//   o_dbg_state               current FSM state (0 IDLE, 1 SETUP, 2 ACCESS)
// -----------------------------------------------------------------------------
module apb_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic                  i_cmd_valid,
    output logic                  o_cmd_ready,
    input  logic                  i_cmd_write,
    input  logic [ADDR_WIDTH-1:0] i_cmd_addr,
    input  logic [DATA_WIDTH-1:0] i_cmd_wdata,
    output logic                  o_rsp_valid,
    output logic [DATA_WIDTH-1:0] o_rsp_rdata,
    output logic                  o_rsp_err,
    output logic                  o_rsp_timeout,
    output logic [ADDR_WIDTH-1:0] PADDR,
    output logic                  PWRITE,
    output logic [DATA_WIDTH-1:0] PWDATA,
    output logic                  PSELx,
    output logic                  PENABLE,
    input  logic [DATA_WIDTH-1:0] PRDATA,
    input  logic                  PREADY,
    input  logic                  PSLVERR,
    output logic [1:0]            o_dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t                state_q,     state_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  psel_q,      psel_d;
    logic                  penable_q,   penable_d;
    logic [ADDR_WIDTH-1:0] paddr_q,     paddr_d;
    logic                  pwrite_q,    pwrite_d;
    logic [DATA_WIDTH-1:0] pwdata_q,    pwdata_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q,   rsp_err_d;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             rsp_timeout_q, rsp_timeout_d;
`endif

    // ---------------------------------------------------------------------
    // Next-state and registered-output logic
    // ---------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        psel_d      = psel_q;
        penable_d   = penable_q;
        paddr_d     = paddr_q;
        pwrite_d    = pwrite_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef APB_MASTER_TIMEOUT_EN
        wait_cnt_d    = wait_cnt_q;
        rsp_timeout_d = rsp_timeout_q;
`endif

        unique case (state_q)
            ST_IDLE: begin
                if (i_cmd_valid && cmd_ready_q) begin
                    state_d     = ST_SETUP;
                    cmd_ready_d = 1'b0;
                    psel_d      = 1'b1;
                    penable_d   = 1'b0;
                    paddr_d     = i_cmd_addr;
                    pwrite_d    = i_cmd_write;
                    pwdata_d    = i_cmd_wdata;
                end
            end

            ST_SETUP: begin
                state_d   = ST_ACCESS;
                penable_d = 1'b1;
`ifdef APB_MASTER_TIMEOUT_EN
                wait_cnt_d = '0;
`endif
            end

            ST_ACCESS: begin
                if (PREADY) begin
                    // Normal completion; wins over a simultaneous timeout.
                    state_d     = ST_IDLE;
                    cmd_ready_d = 1'b1;
                    psel_d      = 1'b0;
                    penable_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = PSLVERR;
                    rsp_rdata_d = pwrite_q ? '0 : PRDATA;
`ifdef APB_MASTER_TIMEOUT_EN
                    rsp_timeout_d = 1'b0;
`endif
                end
`ifdef APB_MASTER_TIMEOUT_EN
                // This low-PREADY cycle brings the count to TIMEOUT_CYCLES.
                else if (wait_cnt_q == CNT_LAST) begin
                    state_d       = ST_IDLE;
                    cmd_ready_d   = 1'b1;
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_err_d     = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_timeout_d = 1'b1;
                end else begin
                    wait_cnt_d = wait_cnt_q + 1'b1;
                end
`endif
            end

            default: begin
                state_d     = ST_IDLE;
                cmd_ready_d = 1'b1;
                psel_d      = 1'b0;
                penable_d   = 1'b0;
            end
        endcase
    end

    // ---------------------------------------------------------------------
    // State and output registers
    // ---------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q     <= ST_IDLE;
            cmd_ready_q <= 1'b1;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            paddr_q     <= paddr_d;
            pwrite_q    <= pwrite_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

`ifdef APB_MASTER_TIMEOUT_EN
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wait_cnt_q    <= '0;
            rsp_timeout_q <= 1'b0;
        end else begin
            wait_cnt_q    <= wait_cnt_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign o_rsp_timeout = rsp_timeout_q;
`else
    assign o_rsp_timeout = 1'b0;
`endif

    assign o_cmd_ready = cmd_ready_q;
    assign PSELx       = psel_q;
    assign PENABLE     = penable_q;
    assign PADDR       = paddr_q;
    assign PWRITE      = pwrite_q;
    assign PWDATA      = pwdata_q;
    assign o_rsp_valid = rsp_valid_q;
    assign o_rsp_rdata = rsp_rdata_q;
    assign o_rsp_err   = rsp_err_q;
    assign o_dbg_state = state_q;

endmodule
